// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each access takes IDLE -> SERVE -> DONE; acks and mem_write are registered.
module dm_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] rmo,
  output logic [DATA_W-1:0] rf_reg_out,
  output logic [ADDR_W-1:0] rmi,
  input  logic [DATA_W-1:0] dm_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DONE
  } state_t;

  state_t              state;
  logic                last;
  logic                gnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                pick;

  // On a tie the port not served last wins; otherwise the lone requester.
  always_comb begin
    pick = p1_req;
    if (p0_req && p1_req) pick = ~last;
  end

  assign rmi        = addr_q;
  assign rmo        = addr_q;
  assign rf_reg_out = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            state     <= SERVE;
            gnt       <= pick;
            last      <= pick;
            we_q      <= pick ? p1_we : p0_we;
            addr_q    <= pick ? p1_addr : p0_addr;
            wdata_q   <= pick ? p1_wdata : p0_wdata;
            mem_write <= pick ? p1_we : p0_we;
            busy      <= 1'b1;
          end
        end
        SERVE: begin
          state     <= DONE;
          mem_write <= 1'b0;
          p0_ack    <= ~gnt;
          p1_ack    <= gnt;
          if (!we_q) begin
            if (gnt) p1_rdata <= dm_out;
            else     p0_rdata <= dm_out;
          end
        end
        DONE: begin
          state  <= IDLE;
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_write <= 1'b0;
          p0_ack    <= 1'b0;
          p1_ack    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dm_arbiter;

  logic       clk;
  logic       reset;
  logic       p0_req, p1_req;
  logic       p0_we, p1_we;
  logic [7:0] p0_addr, p1_addr;
  logic [7:0] p0_wdata, p1_wdata;
  logic       p0_ack, p1_ack;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_write;
  logic [7:0] rmo, rmi, rf_reg_out, dm_out;
  logic       busy;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  dm_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p0_ack     (p0_ack),
    .p1_ack     (p1_ack),
    .p0_rdata   (p0_rdata),
    .p1_rdata   (p1_rdata),
    .mem_write  (mem_write),
    .rmo        (rmo),
    .rf_reg_out (rf_reg_out),
    .rmi        (rmi),
    .dm_out     (dm_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_out = mem[rmi];

  always @(posedge clk) begin
    if (mem_write) mem[rmo] <= rf_reg_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_ack;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_acks", {p1_ack, p0_ack}, 0);
    chk("rst_rmi", rmi, 0);
    chk("rst_rmo", rmo, 0);
    chk("rst_wdata", rf_reg_out, 0);
    chk("rst_rdata", {p1_rdata, p0_rdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // port 0 write 10 <- 155
    p0_req = 1; p0_we = 1; p0_addr = 8'd10; p0_wdata = 8'd155;
    @(negedge clk);
    chk("w_serve_mem_write", mem_write, 1);
    chk("w_serve_rmo", rmo, 10);
    chk("w_serve_wdata", rf_reg_out, 155);
    chk("w_serve_busy", busy, 1);
    chk("w_serve_ack", {p1_ack, p0_ack}, 0);
    @(negedge clk);
    chk("w_done_mem_write", mem_write, 0);
    chk("w_done_ack", {p1_ack, p0_ack}, 2'b01);
    chk("w_mem10", mem[10], 155);
    p0_req = 0;
    @(negedge clk);
    chk("w_idle_ack", {p1_ack, p0_ack}, 0);
    chk("w_idle_busy", busy, 0);

    // port 1 read 10
    p1_req = 1; p1_we = 0; p1_addr = 8'd10;
    @(negedge clk);
    chk("r_serve_mem_write", mem_write, 0);
    chk("r_serve_rmi", rmi, 10);
    @(negedge clk);
    chk("r_done_ack", {p1_ack, p0_ack}, 2'b10);
    chk("r_p1_rdata", p1_rdata, 155);
    chk("r_p0_rdata", p0_rdata, 0);
    chk("r_done_mem_write", mem_write, 0);
    p1_req = 0;
    @(negedge clk);

    // tie from reset: p0 write 3 <- 7, p1 read 3
    reset = 1;
    @(negedge clk);
    reset = 0;
    p0_req = 1; p0_we = 1; p0_addr = 8'd3; p0_wdata = 8'd7;
    p1_req = 1; p1_we = 0; p1_addr = 8'd3;
    @(negedge clk);
    chk("tie_first_write", mem_write, 1);
    chk("tie_first_rmo", rmo, 3);
    @(negedge clk);
    chk("tie_first_ack", {p1_ack, p0_ack}, 2'b01);
    p0_req = 0;
    @(negedge clk);
    chk("tie_gap_busy", busy, 0);
    @(negedge clk);
    chk("tie_second_write", mem_write, 0);
    chk("tie_second_rmi", rmi, 3);
    @(negedge clk);
    chk("tie_second_ack", {p1_ack, p0_ack}, 2'b10);
    chk("tie_p1_rdata", p1_rdata, 7);
    p1_req = 0;
    @(negedge clk);

    // continuous contention: p0 reads 3, p1 writes 20 <- 99
    p0_we = 0; p0_addr = 8'd3;
    p1_we = 1; p1_addr = 8'd20; p1_wdata = 8'd99;
    p0_req = 1; p1_req = 1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      exp_ack = 2'b00;
      if (n % 3 == 2) exp_ack = ((n / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr_ack_c%0d", n), {p1_ack, p0_ack}, exp_ack);
      if (n == 11) begin
        p0_req = 0; p1_req = 0;
      end
    end
    @(negedge clk);
    chk("rr_idle_busy", busy, 0);
    chk("rr_p0_rdata", p0_rdata, 7);
    chk("rr_p1_rdata_kept", p1_rdata, 7);
    chk("rr_mem20", mem[20], 99);

    // reset in the middle of a port 1 write
    p1_we = 1; p1_addr = 8'd30; p1_wdata = 8'h55; p1_req = 1;
    @(negedge clk);
    chk("abort_serve_write", mem_write, 1);
    chk("abort_serve_busy", busy, 1);
    #2 reset = 1;
    #1;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", p1_ack, 0);
    @(negedge clk);
    reset = 0; p1_req = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("abort_no_ack_%0d", n), {p1_ack, busy}, 0);
    end
    chk("abort_mem30", mem[30], 0);

    // next tie after reset goes to port 0
    p0_we = 0; p0_addr = 8'd20; p0_req = 1;
    p1_we = 0; p1_addr = 8'd3;  p1_req = 1;
    @(negedge clk);
    chk("post_rst_rmi", rmi, 20);
    @(negedge clk);
    chk("post_rst_ack", {p1_ack, p0_ack}, 2'b01);
    chk("post_rst_p0_rdata", p0_rdata, 99);
    p0_req = 0; p1_req = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, address width of the data memory and of each requester.
REQ-002 The block SHALL have parameter DATA_W, default 8, data width of the data memory and of each requester.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports p0_req/p1_req  input  1  access request from requester 0/1, held until ack.
REQ-006 The block SHALL have ports p0_we/p1_we  input  1  1 = write, 0 = read; stable while req high.
REQ-007 The block SHALL have ports p0_addr/p1_addr  input  ADDR_W  access address; stable while req high.
REQ-008 The block SHALL have ports p0_wdata/p1_wdata  input  DATA_W  write data; stable while req high.
REQ-009 The block SHALL have ports p0_ack/p1_ack  output  1  one-cycle completion pulse to requester 0/1.
REQ-010 The block SHALL have ports p0_rdata/p1_rdata  output  DATA_W  registered read data, valid while the matching ack is high.
REQ-011 The block SHALL have port mem_write  output  1  DM write enable.
REQ-012 The block SHALL have port rmo  output  ADDR_W  DM write address.
REQ-013 The block SHALL have port rf_reg_out  output  DATA_W  DM write data.
REQ-014 The block SHALL have port rmi  output  ADDR_W  DM read address.
REQ-015 The block SHALL have port dm_out  input  DATA_W  DM combinational read data for address rmi.
REQ-016 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, SERVE, DONE; each state lasts exactly one cycle except IDLE, which lasts while no req is high.
REQ-018 In IDLE with at least one req high, the block SHALL grant one port, latch its we/addr/wdata and the grant id into registers, and go to SERVE.
REQ-019 With both reqs high in IDLE, the block SHALL grant the port not served last (round-robin); last-served pointer reset value = 1, so port 0 wins the first tie.
REQ-020 With a single req high, the block SHALL grant it regardless of the pointer; the pointer SHALL update to the granted port on every grant.
REQ-021 rmi and rmo SHALL both be driven from the latched address register; rf_reg_out SHALL be driven from the latched wdata register.
REQ-022 In SERVE, mem_write SHALL be 1 if the latched we = 1, else 0; mem_write SHALL be 0 in IDLE and DONE.
REQ-023 In SERVE for a read, the block SHALL capture dm_out into the granted port's rdata register at the end of the cycle.
REQ-024 In DONE, the block SHALL assert exactly the granted port's ack for one cycle, then return to IDLE.
REQ-025 p0_rdata/p1_rdata SHALL hold their last captured value until the next read for that port; a write SHALL NOT alter them.
REQ-026 Request-to-ack latency SHALL be 2 cycles after the IDLE cycle that samples req; max throughput SHALL be 1 access per 3 cycles.
REQ-027 A requester keeping req high across the edge ending DONE SHALL be treated as a new request in the following IDLE cycle.
REQ-028 req or payload changes during SERVE/DONE SHALL be ignored; only latched values are used.
REQ-029 Requests with identical addresses from both ports SHALL be serialised; the second access SHALL observe the first's write.

Reset
REQ-030 On reset assertion, the FSM SHALL go to IDLE immediately; mem_write, p0_ack, p1_ack and busy SHALL go to 0 without waiting for clk.
REQ-031 On reset, rmi, rmo, rf_reg_out, p0_rdata and p1_rdata SHALL be 0; the last-served pointer SHALL be 1.
REQ-032 Reset during SERVE or DONE SHALL abort the access with no ack; a DM write already clocked before reset SHALL stand.

Verification
REQ-033 Port 0 write, addr 10, data 155 -> mem_write = 1 for exactly one cycle with rmo = 10 and rf_reg_out = 155; p0_ack pulses 2 cycles after the IDLE sample.
REQ-034 Port 1 read, addr 10, after REQ-033 -> p1_ack pulses with p1_rdata = 155; p0_rdata unchanged; mem_write stays 0.
REQ-035 Both ports request from reset (p0 write addr 3 = 7; p1 read addr 3) -> p0 is served first; p1 is served next and p1_rdata = 7.
REQ-036 Both ports hold req continuously for 4 accesses -> grants alternate 0,1,0,1; each ack is one cycle long; accesses are 3 cycles apart.
REQ-037 Reset asserted mid-SERVE of a port 1 write -> mem_write drops immediately, no p1_ack, busy = 0, and the next tie is granted to port 0.
